prod_stutter_cmp: RTL
=====================

PROD_STUTTER_CMP -- requirements
Module: prod_stutter_cmp

Interface
REQ-001 SHALL have parameter W, default 32: bit width of one observation channel.
REQ-002 SHALL have parameter CH, default 4: number of channels per observation.
REQ-003 SHALL have parameter DEPTH, default 8: per-side buffer entries; power of two, at least 2.
REQ-004 SHALL have parameter MAX_STALL, default 64: stall limit in cycles, used only with STALL_TIMEOUT_EN.
REQ-005 SHALL have one clock and a synchronous, active-high reset, with the ports listed in REQ-006 to REQ-016.
REQ-006 XCLK  in  1  sole clock; all state updates on its rising edge.
REQ-007 XRES  in  1  synchronous active-high reset.
REQ-008 LVALID  in  1  Left copy presents an observation this cycle.
REQ-009 LDATA  in  CH*W  Left observation; channel k occupies bits [k*W +: W].
REQ-010 RVALID  in  1  Right copy presents an observation this cycle.
REQ-011 RDATA  in  CH*W  Right observation, same layout as LDATA.
REQ-012 CHMASK  in  CH  per-channel compare enable; 0 = channel ignored.
REQ-013 src_cand_equiv  out  1  1 while no divergence has been detected since reset.
REQ-014 mismatch_ch  out  CH  sticky per-channel mismatch flags.
REQ-015 overflow  out  1  sticky flag: an observation was pushed into a full buffer.
REQ-016 timeout  out  1  sticky stall-timeout flag.

Function
REQ-017 SHALL keep one FIFO per side, each DEPTH entries of CH*W bits; LVALID/RVALID pushes LDATA/RDATA.
REQ-018 SHALL pop both FIFO heads in the same cycle when both FIFOs are non-empty, and compare them in that cycle.
REQ-019 SHALL allow push and pop on one side in the same cycle; a full FIFO popped that cycle accepts the push with no overflow.
REQ-020 SHALL treat channel k as mismatching when CHMASK[k]=1 and the channel-k fields of the two heads differ.
REQ-021 SHALL set mismatch_ch[k] and clear src_cand_equiv on the clock edge ending the compare cycle, i.e. 1-cycle latency.
REQ-022 SHALL, on a push into a full FIFO with no same-cycle pop, drop the entry, set overflow and clear src_cand_equiv.
REQ-023 SHALL make src_cand_equiv sticky at 0 until reset; comparisons continue afterwards and mismatch_ch keeps accumulating.
REQ-024 SHALL let stuttering (one side idle while the other pushes) alone never clear src_cand_equiv.
REQ-025 SHALL let an observation pushed while its FIFO is empty reach the head one cycle later (pointer wrap-around modulo DEPTH).

Reset
REQ-026 SHALL, when XRES=1 at a clock edge, empty both FIFOs and set src_cand_equiv=1, mismatch_ch=0, overflow=0, timeout=0 and the stall counter to 0.
REQ-027 SHALL, on reset asserted mid-operation, discard pending entries and ignore any LVALID/RVALID sampled in that same cycle.

Configuration
REQ-028 SHALL use macro STALL_TIMEOUT_EN: when defined, a counter counts consecutive cycles in which exactly one FIFO is non-empty and clears whenever that condition is false.
REQ-029 SHALL, with STALL_TIMEOUT_EN defined, set timeout and clear src_cand_equiv when the counter reaches MAX_STALL.
REQ-030 SHALL, without STALL_TIMEOUT_EN, implement no counter and tie timeout to 0.

Verification (W=8, CH=2, DEPTH=4, CHMASK=2'b11)
REQ-031 Left and Right push identical 16'h1234 in the same cycle -> src_cand_equiv stays 1, both FIFOs empty one cycle later.
REQ-032 Left pushes 3 entries over cycles 0-2, Right pushes the same 3 entries over cycles 5-7 -> src_cand_equiv stays 1, no flags set.
REQ-033 Left 16'hAB01, Right 16'hAB02 -> mismatch_ch=2'b01 and src_cand_equiv=0 one cycle after the compare; with CHMASK=2'b10 -> no flag.
REQ-034 Left pushes 5 entries while Right stays idle -> overflow=1 after the 5th push and src_cand_equiv=0.
REQ-035 XRES pulsed after a failure with entries pending -> all flags cleared, src_cand_equiv=1, FIFOs empty.
REQ-036 STALL_TIMEOUT_EN defined, MAX_STALL=10, Left pushes one entry and Right stays idle -> timeout=1 at stall cycle 10; not set when Right pushes at cycle 9.

Source files
------------

// File: rtl/prod_stutter_cmp.sv
// Lockstep comparator: buffers two observation streams and flags divergence.
// Optional stall watchdog enabled by defining STALL_TIMEOUT_EN.
module prod_stutter_cmp #(
    parameter int W         = 32,
    parameter int CH        = 4,
    parameter int DEPTH     = 8,
    parameter int MAX_STALL = 64
) (
    input  logic          XCLK,
    input  logic          XRES,
    input  logic          LVALID,
    input  logic [CH*W-1:0] LDATA,
    input  logic          RVALID,
    input  logic [CH*W-1:0] RDATA,
    input  logic [CH-1:0] CHMASK,
    output logic          src_cand_equiv,
    output logic [CH-1:0] mismatch_ch,
    output logic          overflow,
    output logic          timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [CH*W-1:0] l_mem [DEPTH];
    logic [CH*W-1:0] r_mem [DEPTH];

    logic [AW-1:0] l_wr, l_rd, r_wr, r_rd;
    logic [AW:0]   l_cnt, r_cnt;

    logic l_ne, r_ne, l_full, r_full;
    logic pop, l_push, r_push, l_ovf, r_ovf;
    logic stall_hit;

    logic [CH*W-1:0] l_head, r_head;
    logic [CH-1:0]   diff;

    assign l_ne   = (l_cnt != '0);
    assign r_ne   = (r_cnt != '0);
    assign l_full = (l_cnt == FULL_CNT);
    assign r_full = (r_cnt == FULL_CNT);

    // Heads leave together; a pop frees a slot for a same-cycle push.
    assign pop    = l_ne & r_ne;
    assign l_push = LVALID & (~l_full | pop);
    assign r_push = RVALID & (~r_full | pop);
    assign l_ovf  = LVALID & l_full & ~pop;
    assign r_ovf  = RVALID & r_full & ~pop;

    assign l_head = l_mem[l_rd];
    assign r_head = r_mem[r_rd];

    always_comb begin
        diff = '0;
        for (int k = 0; k < CH; k++) begin
            if (pop && CHMASK[k] &&
                (l_head[k*W +: W] != r_head[k*W +: W])) begin
                diff[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge XCLK) begin
        if (l_push) begin
            l_mem[l_wr] <= LDATA;
        end
        if (r_push) begin
            r_mem[r_wr] <= RDATA;
        end
    end

    always_ff @(posedge XCLK) begin
        if (XRES) begin
            l_wr  <= '0;
            l_rd  <= '0;
            l_cnt <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (l_push) begin
                l_wr <= l_wr + 1'b1;
            end
            if (r_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (pop) begin
                l_rd <= l_rd + 1'b1;
                r_rd <= r_rd + 1'b1;
            end
            l_cnt <= l_cnt + (AW+1)'(l_push) - (AW+1)'(pop);
            r_cnt <= r_cnt + (AW+1)'(r_push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge XCLK) begin
        if (XRES) begin
            src_cand_equiv <= 1'b1;
            mismatch_ch    <= '0;
            overflow       <= 1'b0;
        end else begin
            mismatch_ch <= mismatch_ch | diff;
            overflow    <= overflow | l_ovf | r_ovf;
            if ((|diff) || l_ovf || r_ovf || stall_hit) begin
                src_cand_equiv <= 1'b0;
            end
        end
    end

`ifdef STALL_TIMEOUT_EN
    localparam int SW = $clog2(MAX_STALL + 1);

    logic [SW-1:0] stall_cnt;
    logic          stall;

    assign stall     = l_ne ^ r_ne;
    assign stall_hit = stall && ((int'(stall_cnt) + 1) == MAX_STALL);

    // Saturates so a persisting stall cannot wrap back below the limit.
    always_ff @(posedge XCLK) begin
        if (XRES) begin
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            if (!stall) begin
                stall_cnt <= '0;
            end else if (stall_cnt != SW'(MAX_STALL)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (stall_hit) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    logic unused_stall_cfg;

    assign unused_stall_cfg = (MAX_STALL > 0);
    assign stall_hit        = 1'b0;
    assign timeout          = 1'b0;
`endif

endmodule
